// File: rtl/sobel_seq_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DRAIN
    } seq_state_t;

    // Tap index along one axis; the signed offset is (index - 1).
    localparam logic [1:0] TAP_NEG  = 2'd0;
    localparam logic [1:0] TAP_ZERO = 2'd1;
    localparam logic [1:0] TAP_POS  = 2'd2;

    localparam int unsigned TAPS_PER_PIXEL = 9;

    // Bits needed to hold values 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_win_addr_gen.sv
// 3x3 window walker: centre pixel in raster order, taps in raster order,
// source address built from incremental row bases.
module sobel_win_addr_gen
    import sobel_seq_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds,
    output logic              o_last_tap,
    output logic              o_last_pixel
);

    localparam int unsigned       X_W        = cnt_w(IMG_W);
    localparam int unsigned       Y_W        = cnt_w(IMG_H);
    localparam logic [X_W-1:0]    X_MAX      = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_BACK   = ADDR_W'(0) - ROW_STRIDE;

    logic [X_W-1:0]    r_cx;
    logic [Y_W-1:0]    r_cy;
    logic [1:0]        r_tx;
    logic [1:0]        r_ty;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_tap_row;
    logic [ADDR_W-1:0] w_col;

    // r_tap_row tracks (cy + ty - 1) * IMG_W modulo 2^ADDR_W; it wraps above row 0
    // but is only used when the tap is in bounds.
    assign w_col        = ADDR_W'(r_cx) + ADDR_W'(r_tx) - ADDR_W'(1);
    assign o_addr       = r_tap_row + w_col;
    assign o_in_bounds  = !((r_cx == '0    && r_tx == TAP_NEG) ||
                            (r_cx == X_MAX && r_tx == TAP_POS) ||
                            (r_cy == '0    && r_ty == TAP_NEG) ||
                            (r_cy == Y_MAX && r_ty == TAP_POS));
    assign o_last_tap   = (r_tx == TAP_POS) && (r_ty == TAP_POS);
    assign o_last_pixel = (r_cx == X_MAX) && (r_cy == Y_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
            r_cx       <= '0;
            r_cy       <= '0;
            r_tx       <= TAP_NEG;
            r_ty       <= TAP_NEG;
            r_row_base <= '0;
            r_tap_row  <= ROW_BACK;
        end else if (i_step) begin
            if (r_tx != TAP_POS) begin
                r_tx <= r_tx + 2'd1;
            end else begin
                r_tx <= TAP_NEG;
                if (r_ty != TAP_POS) begin
                    r_ty      <= r_ty + 2'd1;
                    r_tap_row <= r_tap_row + ROW_STRIDE;
                end else begin
                    r_ty <= TAP_NEG;
                    if (r_cx != X_MAX) begin
                        r_cx      <= r_cx + X_W'(1);
                        r_tap_row <= r_row_base - ROW_STRIDE;
                    end else begin
                        r_cx <= '0;
                        if (r_cy != Y_MAX) begin
                            r_cy       <= r_cy + Y_W'(1);
                            r_row_base <= r_row_base + ROW_STRIDE;
                            r_tap_row  <= r_row_base;
                        end else begin
                            r_cy       <= '0;
                            r_row_base <= '0;
                            r_tap_row  <= ROW_BACK;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Feeds SobelFilter 3x3 taps from source memory and writes its results to
// destination memory. SOBEL_SEQ_PERF_CNT_EN adds the o_stall_cnt counter.
module sobel_frame_sequencer
    import sobel_seq_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_active,
    output logic              o_done,
    output logic              o_src_rd,
    output logic [ADDR_W-1:0] o_src_addr,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_rgb_vld,
    output logic [DATA_W-1:0] o_rgb_data,
    input  logic              i_rgb_busy,
    input  logic              i_avg_vld,
    input  logic [DATA_W-1:0] i_avg_data,
    output logic              o_avg_busy,
    output logic              o_dst_we,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic [DATA_W-1:0] o_dst_data
`ifdef SOBEL_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt
`endif
);

    localparam int unsigned    PIX_N    = IMG_W * IMG_H;
    localparam int unsigned    RES_W    = cnt_w(PIX_N + 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(PIX_N);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_start;
    logic              w_step;
    logic              w_load_zero;
    logic              w_load_src;
    logic [ADDR_W-1:0] w_tap_addr;
    logic              w_in_bounds;
    logic              w_last_tap;
    logic              w_last_pixel;

    logic              r_rgb_vld;
    logic [DATA_W-1:0] r_rgb_data;
    logic              r_done;
    logic [RES_W-1:0]  r_res_cnt;
    logic              r_dst_we;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [DATA_W-1:0] r_dst_data;

    sobel_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start),
        .i_step       (w_step),
        .o_addr       (w_tap_addr),
        .o_in_bounds  (w_in_bounds),
        .o_last_tap   (w_last_tap),
        .o_last_pixel (w_last_pixel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_load_zero = 1'b0;
        w_load_src  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_in_bounds) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_load_zero = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_WAIT: begin
                w_load_src  = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!i_rgb_busy) begin
                    w_step      = 1'b1;
                    w_state_nxt = (w_last_tap && w_last_pixel) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (r_res_cnt == RES_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_rgb_vld  <= 1'b0;
            r_rgb_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rgb_vld <= (w_state_nxt == S_SEND);
            r_done    <= (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
            if (w_load_zero) begin
                r_rgb_data <= '0;
            end else if (w_load_src) begin
                r_rgb_data <= i_src_data;
            end
        end
    end

    // Result path runs independently of the feed FSM; overflow results are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_res_cnt  <= '0;
            r_dst_we   <= 1'b0;
            r_dst_addr <= '0;
            r_dst_data <= '0;
        end else begin
            r_dst_we <= 1'b0;
            if (w_start) begin
                r_res_cnt <= '0;
            end else if (r_state != S_IDLE && i_avg_vld && r_res_cnt != RES_LAST) begin
                r_dst_we   <= 1'b1;
                r_dst_addr <= ADDR_W'(r_res_cnt);
                r_dst_data <= i_avg_data;
                r_res_cnt  <= r_res_cnt + RES_W'(1);
            end
        end
    end

`ifdef SOBEL_SEQ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst || w_start) begin
            r_stall_cnt <= '0;
        end else if (r_rgb_vld && i_rgb_busy && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    // Stall counter not built.
`endif

    assign o_active   = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_src_rd   = (r_state == S_FETCH) && w_in_bounds;
    assign o_src_addr = o_src_rd ? w_tap_addr : '0;
    assign o_rgb_vld  = r_rgb_vld;
    assign o_rgb_data = r_rgb_data;
    assign o_avg_busy = (r_state == S_IDLE);
    assign o_dst_we   = r_dst_we;
    assign o_dst_addr = r_dst_addr;
    assign o_dst_data = r_dst_data;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Self-checking bench for sobel_frame_sequencer on a 4x3 frame with a
// behavioural SobelFilter stand-in (sum of 9 taps, 5-cycle latency).
module tb_sobel_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        o_active, o_done, o_src_rd, o_rgb_vld, o_avg_busy, o_dst_we;
    logic [15:0] o_src_addr, o_dst_addr;
    logic [31:0] o_rgb_data, o_dst_data;
    logic [31:0] i_src_data = '0;
    logic        i_rgb_busy = 1'b0;
    logic        i_avg_vld = 1'b0;
    logic [31:0] i_avg_data = '0;
`ifdef SOBEL_SEQ_PERF_CNT_EN
    logic [31:0] o_stall_cnt;
`endif

    always #5 clk = ~clk;

    sobel_frame_sequencer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_active   (o_active),
        .o_done     (o_done),
        .o_src_rd   (o_src_rd),
        .o_src_addr (o_src_addr),
        .i_src_data (i_src_data),
        .o_rgb_vld  (o_rgb_vld),
        .o_rgb_data (o_rgb_data),
        .i_rgb_busy (i_rgb_busy),
        .i_avg_vld  (i_avg_vld),
        .i_avg_data (i_avg_data),
        .o_avg_busy (o_avg_busy),
        .o_dst_we   (o_dst_we),
        .o_dst_addr (o_dst_addr),
        .o_dst_data (o_dst_data)
`ifdef SOBEL_SEQ_PERF_CNT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [NPIX];

    // Reference model: expected tap stream, per-pixel sums, read and zero-tap counts.
    logic [31:0] exp_taps[$];
    logic [31:0] exp_sums[$];
    int          exp_reads;
    int          exp_zero;

    // Environment / monitor state.
    int          cyc = 0;
    int          busy_mode = 0;
    int          force_left = 0;
    int          stab_err = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] tap_log[$];
    int          src_rd_cnt = 0;
    int          first_rd_addr = -1;
    int          dst_addr_log[$];
    logic [31:0] dst_data_log[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_we_cyc = 0;
    int          done_active_err = 0;
    logic [31:0] stall_at_done = '0;
    bit          rd_pending = 1'b0;
    int          rd_addr = 0;
    int          f_tapn = 0;
    logic [31:0] f_acc = '0;
    int          res_due[$];
    logic [31:0] res_val[$];
    bit          flush_req = 1'b0;

    function automatic logic [31:0] mem_rd(input int a);
        if (a >= 0 && a < NPIX) return mem[a];
        return 'x;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (flush_req) begin
            f_tapn = 0;
            f_acc = '0;
            res_due.delete();
            res_val.delete();
            rd_pending = 1'b0;
            prev_stall = 1'b0;
            flush_req = 1'b0;
        end
        if (o_src_rd) begin
            if (src_rd_cnt == 0) first_rd_addr = int'(o_src_addr);
            src_rd_cnt++;
        end
        if (o_dst_we) begin
            dst_addr_log.push_back(int'(o_dst_addr));
            dst_data_log.push_back(o_dst_data);
            last_we_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (o_active) done_active_err++;
`ifdef SOBEL_SEQ_PERF_CNT_EN
            stall_at_done = o_stall_cnt;
`endif
        end
        if (prev_stall && (!o_rgb_vld || o_rgb_data !== prev_data)) stab_err++;

        i_src_data = rd_pending ? mem_rd(rd_addr) : $urandom;
        rd_pending = o_src_rd;
        rd_addr    = int'(o_src_addr);

        case (busy_mode)
            1: i_rgb_busy = 1'($urandom_range(0, 1));
            2: begin
                if (o_rgb_vld && force_left > 0) begin
                    i_rgb_busy = 1'b1;
                    force_left--;
                end else begin
                    i_rgb_busy = 1'b0;
                end
            end
            default: i_rgb_busy = 1'b0;
        endcase

        if (o_rgb_vld && !i_rgb_busy) begin
            tap_log.push_back(o_rgb_data);
            f_acc += o_rgb_data;
            f_tapn++;
            if (f_tapn == 9) begin
                res_due.push_back(cyc + 5);
                res_val.push_back(f_acc);
                f_tapn = 0;
                f_acc = '0;
            end
        end
        prev_stall = o_rgb_vld && i_rgb_busy;
        prev_data  = o_rgb_data;

        if (res_due.size() > 0 && res_due[0] <= cyc) begin
            i_avg_vld  = 1'b1;
            i_avg_data = res_val.pop_front();
            void'(res_due.pop_front());
        end else begin
            i_avg_vld  = 1'b0;
            i_avg_data = $urandom;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_ref();
        logic [31:0] v, s;
        exp_taps.delete();
        exp_sums.delete();
        exp_reads = 0;
        exp_zero = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                s = '0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H) begin
                            v = mem[(y + dy) * W + (x + dx)];
                            exp_reads++;
                        end else begin
                            v = '0;
                        end
                        if (v == 0) exp_zero++;
                        exp_taps.push_back(v);
                        s += v;
                    end
                end
                exp_sums.push_back(s);
            end
        end
    endtask

    task automatic fill_mem_random();
        for (int a = 0; a < NPIX; a++) mem[a] = $urandom;
        build_ref();
    endtask

    task automatic clear_logs();
        tap_log.delete();
        dst_addr_log.delete();
        dst_data_log.delete();
        src_rd_cnt = 0;
        first_rd_addr = -1;
        done_cnt = 0;
        stab_err = 0;
        done_active_err = 0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        clear_logs();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        n_vec++;
        if (o_active !== 1'b1) begin
            n_err++;
            $display("FAIL active_after_start got %b want 1", o_active);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        flush_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({o_active, o_done, o_src_rd, o_rgb_vld, o_avg_busy, o_dst_we} !== 6'b000010) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000010",
                     {o_active, o_done, o_src_rd, o_rgb_vld, o_avg_busy, o_dst_we});
        end
        n_vec++;
        if (o_src_addr !== 16'd0 || o_dst_addr !== 16'd0 || o_rgb_data !== 32'd0 || o_dst_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_buses got src_addr=%h dst_addr=%h rgb=%h dst=%h want all 0",
                     o_src_addr, o_dst_addr, o_rgb_data, o_dst_data);
        end
        i_rst = 1'b1;
    endtask

    task automatic test_basic();
        int zeros;
        busy_mode = 0;
        fill_mem_random();
        start_frame();
        n_vec++;
        if (o_avg_busy !== 1'b0) begin
            n_err++;
            $display("FAIL avg_busy_active got %b want 0", o_avg_busy);
        end
        wait_done();
        n_vec++;
        if (src_rd_cnt != 70 || exp_reads != 70) begin
            n_err++;
            $display("FAIL basic_src_reads got %0d want 70", src_rd_cnt);
        end
        n_vec++;
        if (tap_log.size() != 108) begin
            n_err++;
            $display("FAIL basic_tap_count got %0d want 108", tap_log.size());
        end
        zeros = 0;
        foreach (tap_log[i]) if (tap_log[i] == 0) zeros++;
        n_vec++;
        if (zeros != exp_zero) begin
            n_err++;
            $display("FAIL basic_zero_taps got %0d want %0d", zeros, exp_zero);
        end
        for (int i = 0; i < exp_taps.size() && i < tap_log.size(); i++) begin
            n_vec++;
            if (tap_log[i] !== exp_taps[i]) begin
                n_err++;
                $display("FAIL basic_tap[%0d] got %h want %h", i, tap_log[i], exp_taps[i]);
            end
        end
        n_vec++;
        if (dst_addr_log.size() != 12) begin
            n_err++;
            $display("FAIL basic_write_count got %0d want 12", dst_addr_log.size());
        end
        for (int i = 0; i < 12 && i < dst_addr_log.size(); i++) begin
            n_vec++;
            if (dst_addr_log[i] != i || dst_data_log[i] !== exp_sums[i]) begin
                n_err++;
                $display("FAIL basic_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, dst_addr_log[i], dst_data_log[i], i, exp_sums[i]);
            end
        end
        n_vec++;
        if (done_cyc != last_we_cyc + 1 || done_active_err != 0) begin
            n_err++;
            $display("FAIL done_timing got done_cyc=%0d last_we=%0d active_at_done=%0d want done=last_we+1 active 0",
                     done_cyc, last_we_cyc, done_active_err);
        end
    endtask

    task automatic test_busy_random();
        busy_mode = 1;
        start_frame();
        wait_done();
        busy_mode = 0;
        n_vec++;
        if (stab_err != 0) begin
            n_err++;
            $display("FAIL busy_stability got %0d unstable cycles want 0", stab_err);
        end
        n_vec++;
        if (tap_log.size() != exp_taps.size()) begin
            n_err++;
            $display("FAIL busy_tap_count got %0d want %0d", tap_log.size(), exp_taps.size());
        end
        for (int i = 0; i < exp_taps.size() && i < tap_log.size(); i++) begin
            n_vec++;
            if (tap_log[i] !== exp_taps[i]) begin
                n_err++;
                $display("FAIL busy_tap[%0d] got %h want %h", i, tap_log[i], exp_taps[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (i >= dst_data_log.size() || dst_data_log[i] !== exp_sums[i]) begin
                n_err++;
                $display("FAIL busy_write[%0d] got %h want %h", i,
                         (i < dst_data_log.size()) ? dst_data_log[i] : 32'hx, exp_sums[i]);
            end
        end
    endtask

    task automatic test_centre();
        logic [31:0] want [9];
        want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd100, 32'd101, 32'd0, 32'd104, 32'd105};
        for (int a = 0; a < NPIX; a++) mem[a] = 32'(a + 100);
        build_ref();
        start_frame();
        wait_done();
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (i >= tap_log.size() || tap_log[i] !== want[i]) begin
                n_err++;
                $display("FAIL centre_tap[%0d] got %h want %h", i,
                         (i < tap_log.size()) ? tap_log[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_mem_random();
        start_frame();
        for (int i = 0; i < 2000 && tap_log.size() < 20; i++) @(posedge clk);
        #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done();
        n_vec++;
        if (tap_log.size() != exp_taps.size() || src_rd_cnt != exp_reads) begin
            n_err++;
            $display("FAIL midstart_counts got taps=%0d reads=%0d want %0d/%0d",
                     tap_log.size(), src_rd_cnt, exp_taps.size(), exp_reads);
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (i >= dst_data_log.size() || dst_addr_log[i] != i || dst_data_log[i] !== exp_sums[i]) begin
                n_err++;
                $display("FAIL midstart_write[%0d] got %h want %h", i,
                         (i < dst_data_log.size()) ? dst_data_log[i] : 32'hx, exp_sums[i]);
            end
        end
        start_frame();
        wait_done();
        n_vec++;
        if (first_rd_addr != 0) begin
            n_err++;
            $display("FAIL restart_first_addr got %0d want 0", first_rd_addr);
        end
        for (int i = 0; i < exp_taps.size(); i++) begin
            n_vec++;
            if (i >= tap_log.size() || tap_log[i] !== exp_taps[i]) begin
                n_err++;
                $display("FAIL restart_tap[%0d] got %h want %h", i,
                         (i < tap_log.size()) ? tap_log[i] : 32'hx, exp_taps[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_mem_random();
        start_frame();
        for (int i = 0; i < 2000 && tap_log.size() < 40; i++) @(posedge clk);
        #1;
        n_vec++;
        if (tap_log.size() != 40) begin
            n_err++;
            $display("FAIL rstmid_reach40 got %0d want 40", tap_log.size());
        end
        i_rst = 1'b0;
        flush_req = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b1;
        n_vec++;
        if ({o_active, o_done, o_src_rd, o_rgb_vld, o_avg_busy, o_dst_we} !== 6'b000010 ||
            o_src_addr !== 16'd0 || o_rgb_data !== 32'd0 || o_dst_addr !== 16'd0 || o_dst_data !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs got flags=%b src=%h rgb=%h dst=%h/%h want 000010 and zeros",
                     {o_active, o_done, o_src_rd, o_rgb_vld, o_avg_busy, o_dst_we},
                     o_src_addr, o_rgb_data, o_dst_addr, o_dst_data);
        end
        repeat (3) @(posedge clk);
        start_frame();
        wait_done();
        n_vec++;
        if (dst_addr_log.size() != 12) begin
            n_err++;
            $display("FAIL rstmid_write_count got %0d want 12", dst_addr_log.size());
        end
        for (int i = 0; i < 12 && i < dst_addr_log.size(); i++) begin
            n_vec++;
            if (dst_addr_log[i] != i || dst_data_log[i] !== exp_sums[i]) begin
                n_err++;
                $display("FAIL rstmid_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, dst_addr_log[i], dst_data_log[i], i, exp_sums[i]);
            end
        end
    endtask

`ifdef SOBEL_SEQ_PERF_CNT_EN
    task automatic test_perf();
        force_left = 17;
        busy_mode = 2;
        start_frame();
        wait_done();
        busy_mode = 0;
        n_vec++;
        if (stall_at_done !== 32'd17) begin
            n_err++;
            $display("FAIL stall_at_done got %0d want 17", stall_at_done);
        end
        n_vec++;
        if (o_stall_cnt !== 32'd17) begin
            n_err++;
            $display("FAIL stall_hold got %0d want 17", o_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_busy_random();
        test_centre();
        test_start_ignored();
        test_reset_mid();
`ifdef SOBEL_SEQ_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_frame_sequencer.md
# sobel_frame_sequencer

Frame-level controller that drives the SobelFilter HLS core from a source pixel memory and collects its results into a destination memory. For every output pixel it walks the 3x3 window in raster order. It reads each in-bounds neighbour and substitutes zero for each out-of-image neighbour, then streams the nine taps over the filter's `rgb` vld/busy channel. In parallel it drains the filter's `avg` channel into consecutive destination addresses and signals completion once the whole frame is written.

## Interface
- `IMG_W`, 256, frame width in pixels (≥2)
- `IMG_H`, 256, frame height in pixels (≥2)
- `ADDR_W`, 16, memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `DATA_W`, 32, pixel/result word width
- `i_clk` in 1: single clock, all logic rising-edge
- `i_rst` in 1: reset, synchronous, active-low
- `i_start` in 1: start one frame; sampled only in IDLE
- `o_active` out 1: high from the cycle after start acceptance until `o_done`
- `o_done` out 1: one-cycle pulse when the last result is written
- `o_src_rd` out 1: source read strobe
- `o_src_addr` out ADDR_W: source address, y*IMG_W+x
- `i_src_data` in DATA_W: read data, valid exactly 1 cycle after `o_src_rd`
- `o_rgb_vld` out 1: tap valid to filter
- `o_rgb_data` out DATA_W: tap data
- `i_rgb_busy` in 1: filter not ready; transfer when `o_rgb_vld && !i_rgb_busy`
- `i_avg_vld` in 1: filter result valid
- `i_avg_data` in DATA_W: filter result
- `o_avg_busy` out 1: 1 in IDLE, 0 otherwise
- `o_dst_we` out 1: destination write strobe
- `o_dst_addr` out ADDR_W: result index 0..IMG_W*IMG_H-1
- `o_dst_data` out DATA_W: result word

## Operation
- Feed FSM states and transitions:
  - IDLE: `i_start` moves to FETCH; counters clear.
  - FETCH, tap in-bounds: assert `o_src_rd`, drive `o_src_addr`, go to WAIT.
  - FETCH, tap out-of-bounds: no read, load data 0, go to SEND.
  - WAIT: capture `i_src_data` into the tap register, go to SEND.
  - SEND: hold `o_rgb_vld`=1 with stable data until the transfer. Then advance the tap. After tap 9 of the last pixel go to DRAIN, otherwise go to FETCH.
  - DRAIN: wait for the result count to reach IMG_W*IMG_H, then pulse `o_done` and return to IDLE.
- Tap order for centre (x,y): dy=-1,0,+1 outer; dx=-1,0,+1 inner. A tap is out of bounds when x+dx∉[0,IMG_W-1] or y+dy∉[0,IMG_H-1].
- Centre pixels advance in raster order, x fastest.
- Addresses come from incremental row-base and column counters; no multiplier.
- Result path, independent of the feed FSM:
  - Every `i_avg_vld` cycle while not IDLE writes `i_avg_data` at the result counter, then increments the counter.
  - Results beyond IMG_W*IMG_H are dropped.
- `i_start` while not IDLE is ignored.
- Reset mid-frame:
  - Next edge returns all state to IDLE and clears counters.
  - Outputs reset values: all 0 except `o_avg_busy`=1.
  - In-flight filter results are not tracked.

## Timing
- Start accepted at edge t: `o_active`=1 and state FETCH from t+1.
- In-bounds tap: FETCH, WAIT, SEND gives a minimum of 3 cycles per tap.
- Out-of-bounds tap: FETCH, SEND gives a minimum of 2 cycles per tap.
- `o_rgb_vld` is registered and deasserts the cycle after the transfer. There are no back-to-back transfers.
- `o_dst_we`/`addr`/`data` are registered 1 cycle after the `i_avg_vld` sample.
- `o_done` is asserted the cycle after the final `o_dst_we`; `o_active` drops in the same cycle.
- If the final result arrives in the same cycle as the final tap transfer, it is still written, and `o_done` follows DRAIN entry by one cycle.

## Configuration
- `SOBEL_SEQ_PERF_CNT_EN` defined:
  - Adds `o_stall_cnt` out 32, which counts cycles with `o_rgb_vld && i_rgb_busy` during the frame.
  - Clears on start acceptance and on reset, saturates at 2^32-1, and holds after done.
- Macro undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `sobel_seq_pkg`:
  - FSM state enum (IDLE, FETCH, WAIT, SEND, DRAIN)
  - tap-offset constants
  - `$clog2`-derived counter widths for coordinates and the pixel count
- Sub-module `sobel_win_addr_gen`:
  - holds the centre x/y, the tap index and the row base
  - outputs the current tap address, an in-bounds flag, last-tap and last-pixel flags
  - advances on a `step` input

## Test plan
- IMG_W=4, IMG_H=3, filter never busy, model returns the sum of 9 taps after 5 cycles. Required:
  - exactly 70 `o_src_rd` pulses
  - 108 tap transfers, 38 of them with data 0
  - 12 writes to addresses 0..11 with the correct sums
  - one `o_done`
- Same frame with `i_rgb_busy` randomly 50% high: `o_rgb_vld`/`data` are stable through every busy cycle, and the transfer sequence is identical to the first test.
- Centre (0,0), src[a]=a+100: taps are 0,0,0,0,100,101,0,104,105.
- `i_start` pulsed mid-frame: ignored, no counter disturbance. A second start after `o_done` re-reads from address 0.
- `i_rst`=0 for one cycle after 40 transfers: next cycle all outputs at reset values. A new start then completes a full 12-result frame.
- `SOBEL_SEQ_PERF_CNT_EN` with exactly 17 forced busy cycles during valid: `o_stall_cnt`=17 at `o_done`.
